// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit for the EX stage.
// One radix-2 step per cycle on magnitudes, sign fix-up on completion.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  output logic        stallreq_from_ex,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_mul;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] acc;
  logic [31:0] qr;
  logic [31:0] bm;

  logic        sgn_op;
  logic        neg_a;
  logic        neg_b;
  logic        accept;
  logic        div_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] dtmp;
  logic [32:0] msum;
  logic [31:0] acc_n;
  logic [31:0] qr_n;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand decode: magnitudes and acceptance of a new op.
  always_comb begin
    sgn_op   = ~op_type[0];
    neg_a    = sgn_op & src_a[31];
    neg_b    = sgn_op & src_b[31];
    abs_a    = neg_a ? (~src_a + 32'd1) : src_a;
    abs_b    = neg_b ? (~src_b + 32'd1) : src_b;
    accept   = (state == IDLE) & op_valid & ~annul;
    div_zero = ~op_type[1] & (src_b == 32'd0);
  end

  // Stall EX while an op is being accepted or iterated; flush and reset win.
  assign stallreq_from_ex = ~rst & ~annul &
                            ((state == BUSY) |
                             ((state == IDLE) & op_valid));

  // One restoring-divide or shift-add-multiply step, plus final sign fix.
  always_comb begin
    dtmp = {acc, qr[31]};
    msum = {1'b0, acc} + (qr[0] ? {1'b0, bm} : 33'd0);
    if (is_mul) begin
      acc_n = msum[32:1];
      qr_n  = {msum[0], qr[31:1]};
    end else if (dtmp >= {1'b0, bm}) begin
      acc_n = 32'(dtmp - {1'b0, bm});
      qr_n  = {qr[30:0], 1'b1};
    end else begin
      acc_n = dtmp[31:0];
      qr_n  = {qr[30:0], 1'b0};
    end
    prod     = {acc_n, qr_n};
    prod_fix = neg_q ? (~prod + 64'd1) : prod;
    q_fix    = neg_q ? (~qr_n + 32'd1) : qr_n;
    r_fix    = neg_r ? (~acc_n + 32'd1) : acc_n;
  end

  // Control FSM with registered outputs and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      is_mul       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      acc          <= 32'd0;
      qr           <= 32'd0;
      bm           <= 32'd0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              state        <= DONE;
              hi           <= src_a;
              lo           <= 32'hFFFF_FFFF;
              result_valid <= 1'b1;
            end else begin
              state  <= BUSY;
              busy   <= 1'b1;
              cnt    <= 5'd0;
              is_mul <= op_type[1];
              neg_q  <= neg_a ^ neg_b;
              neg_r  <= neg_a;
              acc    <= 32'd0;
              qr     <= op_type[1] ? abs_b : abs_a;
              bm     <= op_type[1] ? abs_a : abs_b;
            end
          end
        end
        BUSY: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_n;
            qr  <= qr_n;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              hi           <= is_mul ? prod_fix[63:32] : r_fix;
              lo           <= is_mul ? prod_fix[31:0] : q_fix;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: op_valid  input  1  EX stage presents a mul/div op; held high by EX while stalled.
REQ-004 SHALL have port: op_type  input  2  00 div, 01 divu, 10 mult, 11 multu.
REQ-005 SHALL have port: src_a  input  32  dividend / multiplicand.
REQ-006 SHALL have port: src_b  input  32  divisor / multiplier.
REQ-007 SHALL have port: annul  input  1  pipeline flush; abandons the current op.
REQ-008 SHALL have port: stallreq_from_ex  output  1  stall request to the stall controller.
REQ-009 SHALL have port: result_valid  output  1  one-cycle pulse; hi/lo hold a new result.
REQ-010 SHALL have port: hi  output  32  remainder (div) or upper product (mul).
REQ-011 SHALL have port: lo  output  32  quotient (div) or lower product (mul).
REQ-012 SHALL have port: busy  output  1  high in BUSY state.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE, plus a 5-bit iteration counter cnt.
REQ-014 SHALL, in IDLE with op_valid=1 and annul=0, latch op_type/src_a/src_b, drive stallreq_from_ex=1 combinationally that same cycle, and go to BUSY with cnt=0.
REQ-015 SHALL, for div/divu with src_b=0, go IDLE->DONE directly, with lo=32'hFFFF_FFFF, hi=src_a.
REQ-016 SHALL, in BUSY, perform one shift-subtract (div) or shift-add (mul) step per cycle on operand magnitudes, incrementing cnt; the step at cnt=31 moves to DONE.
REQ-017 SHALL, for signed ops, operate on absolute values and correct signs on the DONE transition: quotient/product negated if operand signs differ; remainder takes the sign of src_a.
REQ-018 SHALL handle signed div 0x8000_0000 / 0xFFFF_FFFF as lo=0x8000_0000, hi=0 (wrap, no trap).
REQ-019 SHALL hold stallreq_from_ex=1 for every BUSY cycle and 0 in DONE and in IDLE without an accepted op.
REQ-020 SHALL, in DONE, assert result_valid=1 for exactly one cycle with hi/lo valid, then go to IDLE unconditionally.
REQ-021 SHALL keep hi/lo stable after DONE until the next result is written.
REQ-022 SHALL define latency: op accepted at cycle N -> result_valid at cycle N+33 (N+1 for divide-by-zero); stallreq high cycles N..N+32.
REQ-023 SHALL NOT accept a new op in DONE; op_valid seen in DONE is ignored (EX advances that cycle).
REQ-024 SHALL, on annul=1 in any state, go to IDLE next cycle, drive stallreq_from_ex=0 that cycle, never assert result_valid for the annulled op, and leave hi/lo unchanged.
REQ-025 SHALL give annul priority over op_valid when both are high in IDLE.

Reset
REQ-026 SHALL, while rst=1, force stallreq_from_ex=0, and on the next edge set state=IDLE, cnt=0, result_valid=0, busy=0, hi=0, lo=0.
REQ-027 SHALL, on rst mid-BUSY, discard the op and emit no result_valid.

Verification
REQ-028 SHALL cover: divu 100/7 -> stall 33 cycles, result_valid at N+33, lo=14, hi=2.
REQ-029 SHALL cover: div -7/2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); mult -3*5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
REQ-030 SHALL cover: multu 0xFFFF_FFFF*0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
REQ-031 SHALL cover: divu 5/0 -> stall 1 cycle, result_valid at N+1, lo=0xFFFF_FFFF, hi=5.
REQ-032 SHALL cover: annul at cycle N+10 of a div -> IDLE at N+11, no result_valid, hi/lo keep prior values; rst at N+5 -> all outputs 0 next cycle.
REQ-033 SHALL cover: back-to-back ops with op_valid held high -> second op accepted in the IDLE cycle after DONE, never in DONE.
